// File: rtl/frame_acc_pkg.sv
// Shared types and constants for the frame accumulator.
// Optional clamp-on-overflow is selected by FRAME_ACC_SATURATE_EN.
package frame_acc_pkg;

  localparam int unsigned DW_DEFAULT        = 26;
  localparam int unsigned CW_DEFAULT        = 8;
  localparam int unsigned MAX_BEATS_DEFAULT = 255;

  localparam logic [DW_DEFAULT-1:0] SAT_MAX = {DW_DEFAULT{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/frame_acc_adder.sv
// DW-bit adder with carry-out; clamps to all-ones on carry when
// FRAME_ACC_SATURATE_EN is defined, otherwise wraps.
module frame_acc_adder
  import frame_acc_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum,
  output logic          carry
);

  logic [DW:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[DW];

`ifdef FRAME_ACC_SATURATE_EN
  assign sum = carry ? {DW{1'b1}} : full[DW-1:0];
`else
  assign sum = full[DW-1:0];
`endif

endmodule

// File: rtl/frame_accumulator_26.sv
// Sums a valid/ready frame of DW-bit words and holds SUM/COUNT/OVF until accepted.
// Overflow handling (clamp vs wrap) follows FRAME_ACC_SATURATE_EN.
module frame_accumulator_26
  import frame_acc_pkg::*;
#(
  parameter int unsigned DW        = DW_DEFAULT,
  parameter int unsigned CW        = CW_DEFAULT,
  parameter int unsigned MAX_BEATS = MAX_BEATS_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] sum,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] acc;
  logic [DW-1:0] acc_nxt;
  logic [DW-1:0] add_a;
  logic          add_carry;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_acc;
  logic          ovf_nxt;
  logic          beat;
  logic          close;

  // First beat of a frame adds to zero, so it loads in_data with no carry.
  frame_acc_adder #(.DW(DW)) u_adder (
    .a     (add_a),
    .b     (in_data),
    .sum   (acc_nxt),
    .carry (add_carry)
  );

  // Output/handshake decode from the current state.
  always_comb begin
    in_ready = 1'b0;
    in_ready = (state != HOLD);
    beat     = in_valid & in_ready;
  end

  always_comb begin
    add_a   = '0;
    cnt_nxt = CW'(1);
    ovf_nxt = 1'b0;
    if (state != IDLE) begin
      add_a   = acc;
      cnt_nxt = cnt + CW'(1);
      ovf_nxt = ovf_acc | add_carry;
    end
    close = beat & (in_last | (cnt_nxt == MAX_CNT));
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat) state_nxt = close ? HOLD : ACCUM;
      ACCUM:   if (close) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Running accumulator, beat counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (beat) begin
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      ovf_acc <= ovf_nxt;
    end
  end

  // Result registers load only on the closing beat and stay put through HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (close) begin
      sum       <= acc_nxt;
      count     <= cnt_nxt;
      ovf       <= ovf_nxt;
      out_valid <= 1'b1;
    end else if ((state == HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
